// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing a single XOR-reduction parity unit among NUM_REQ
// requesters, with valid/ready handshakes on both the request and result sides.
module parity_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  output logic                      res_parity,
  output logic [ID_W-1:0]           res_id,
  input  logic                      res_ready,
  output logic                      busy,
  output logic [15:0]               txn_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_reg;
  logic [DATA_W-1:0]   data_reg;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     gnt_ptr;
  logic [DATA_W-1:0]   gnt_data;
  logic                grant_en;
  logic                granted;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int  pos;
    logic found;
    grant    = '0;
    gnt_id   = '0;
    gnt_ptr  = '0;
    gnt_data = '0;
    found    = 1'b0;
    pos      = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!found && req_valid[i] && (pos == i)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gnt_id   = ID_W'(i);
          gnt_ptr  = (i == int'(NUM_REQ) - 1) ? '0 : ID_W'(i + 1);
          gnt_data = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Grants only in IDLE, or in DONE while the consumer takes the result.
  always_comb begin
    grant_en  = (state == IDLE) || ((state == DONE) && res_ready);
    req_ready = grant_en ? grant : '0;
    granted   = |req_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_reg     <= '0;
      data_reg   <= '0;
      res_valid  <= 1'b0;
      res_parity <= 1'b0;
      res_id     <= '0;
      busy       <= 1'b0;
      txn_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (granted) begin
            data_reg <= gnt_data;
            id_reg   <= gnt_id;
            rr_ptr   <= gnt_ptr;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          res_parity <= (^data_reg) ^ (ODD_PARITY != 0);
          res_id     <= id_reg;
          res_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            txn_count <= txn_count + 16'd1;
            if (granted) begin
              data_reg <= gnt_data;
              id_reg   <= gnt_id;
              rr_ptr   <= gnt_ptr;
              state    <= CALC;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy      <= 1'b0;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter: reset, parity polarity, round-robin order,
// consumer back-pressure and result-counter wrap.
module tb_parity_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         res_valid;
  logic         res_parity;
  logic [1:0]   res_id;
  logic         res_ready;
  logic         busy;
  logic [15:0]  txn_count;

  logic [3:0]   odd_req_ready;
  logic         odd_res_valid;
  logic         odd_res_parity;
  logic [1:0]   odd_res_id;
  logic         odd_busy;
  logic [15:0]  odd_txn_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_txn  = 0;
  logic [3:0] exp_par;
  logic [3:0] one_hot;

  parity_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2), .ODD_PARITY(0)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_parity(res_parity),
    .res_id(res_id), .res_ready(res_ready), .busy(busy), .txn_count(txn_count)
  );

  parity_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2), .ODD_PARITY(1)) u_odd (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(odd_req_ready), .res_valid(odd_res_valid), .res_parity(odd_res_parity),
    .res_id(odd_res_id), .res_ready(res_ready), .busy(odd_busy), .txn_count(odd_txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;
    tick();
    tick();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_parity", 32'(res_parity), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    reset = 1'b0;
    tick();

    // Single requester 0, odd number of ones
    req_data[31:0] = 32'h0000_0001;
    req_valid      = 4'b0001;
    #1;
    check("t2_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("t2_calc_valid", 32'(res_valid), 32'd0);
    check("t2_calc_busy", 32'(busy), 32'd1);
    check("t2_calc_no_grant", 32'(req_ready), 32'd0);
    tick();
    check("t2_res_valid", 32'(res_valid), 32'd1);
    check("t2_parity", 32'(res_parity), 32'd1);
    check("t2_odd_parity", 32'(odd_res_parity), 32'd0);
    check("t2_id", 32'(res_id), 32'd0);
    tick();
    check("t2_txn", 32'(txn_count), 32'd1);
    check("t2_odd_txn", 32'(odd_txn_count), 32'd1);
    check("t2_idle_valid", 32'(res_valid), 32'd0);
    check("t2_idle_busy", 32'(busy), 32'd0);

    // Reset while in CALC discards the word and rewinds the pointer
    req_data[63:32] = 32'h0000_0003;
    req_valid       = 4'b0010;
    tick();
    req_valid = '0;
    reset     = 1'b1;
    tick();
    check("t1_res_valid", 32'(res_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_txn", 32'(txn_count), 32'd0);
    reset = 1'b0;
    tick();
    check("t1_no_result", 32'(res_valid), 32'd0);
    req_data[127:96] = 32'h0000_0001;
    req_valid        = 4'b1010;
    #1;
    check("t1_rr_ptr_zero", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    check("t1_id", 32'(res_id), 32'd1);
    check("t1_parity", 32'(res_parity), 32'd0);
    tick();
    check("t1_txn_after", 32'(txn_count), 32'd1);

    // All ones on requester 2: even count, both polarities
    req_data[95:64] = 32'hFFFF_FFFF;
    req_valid       = 4'b0100;
    #1;
    check("t3_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    check("t3_parity_even", 32'(res_parity), 32'd0);
    check("t3_parity_odd", 32'(odd_res_parity), 32'd1);
    check("t3_id", 32'(res_id), 32'd2);
    tick();
    check("t3_txn", 32'(txn_count), 32'd2);

    // Start round-robin from pointer 0 with all requesters valid
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    exp_txn          = 0;
    req_data[31:0]   = 32'h0000_0003;
    req_data[63:32]  = 32'h0000_0007;
    req_data[95:64]  = 32'h8000_0000;
    req_data[127:96] = 32'h0F0F_0F0F;
    exp_par          = 4'b0110;
    req_valid        = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      one_hot = 4'b0001 << (k % 4);
      check($sformatf("t4_grant_%0d", k), 32'(req_ready), 32'(one_hot));
      tick();
      if (k > 0) exp_txn++;
      check($sformatf("t4_calc_%0d", k), 32'(req_ready), 32'd0);
      check($sformatf("t4_txn_%0d", k), 32'(txn_count), 32'(exp_txn));
      tick();
      check($sformatf("t4_valid_%0d", k), 32'(res_valid), 32'd1);
      check($sformatf("t4_id_%0d", k), 32'(res_id), 32'(k % 4));
      check($sformatf("t4_par_%0d", k), 32'(res_parity), 32'(exp_par[k % 4]));
    end
    req_valid = '0;
    tick();
    exp_txn++;
    check("t4_txn_end", 32'(txn_count), 32'(exp_txn));

    // Consumer stalls in DONE while requester 1 waits
    res_ready       = 1'b0;
    req_data[31:0]  = 32'h0000_0005;
    req_valid       = 4'b0001;
    #1;
    check("t5_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    check("t5_calc_no_grant", 32'(req_ready), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t5_hold_ready_%0d", c), 32'(req_ready), 32'd0);
      check($sformatf("t5_hold_valid_%0d", c), 32'(res_valid), 32'd1);
      check($sformatf("t5_hold_id_%0d", c), 32'(res_id), 32'd0);
      check($sformatf("t5_hold_par_%0d", c), 32'(res_parity), 32'd0);
      check($sformatf("t5_hold_txn_%0d", c), 32'(txn_count), 32'(exp_txn));
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("t5_regrant", 32'(req_ready), 32'h2);
    tick();
    exp_txn++;
    req_valid = '0;
    check("t5_txn", 32'(txn_count), 32'(exp_txn));
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_calc_valid", 32'(res_valid), 32'd0);
    tick();
    check("t5_id", 32'(res_id), 32'd1);
    check("t5_par", 32'(res_parity), 32'd1);
    tick();

    // Counter wrap from 0xFFFF
    force u_dut.txn_count = 16'hFFFF;
    #1;
    release u_dut.txn_count;
    #1;
    check("t6_preset", 32'(txn_count), 32'h0000_FFFF);
    req_data[31:0] = 32'h0000_0001;
    req_valid      = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    check("t6_valid", 32'(res_valid), 32'd1);
    tick();
    check("t6_wrap", 32'(txn_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
